div_sched: RTL and testbench
============================

# div_sched

Two-requester scheduler and sequencer for a shared restoring (shift–subtract) divider. It arbitrates round-robin between two clients, latches the winner's operands and runs the divider one quotient bit per cycle. It returns quotient and remainder through a valid/ready response channel tagged with the requester id. It sits between the arithmetic clients and the divide datapath, which it contains, so no divider is instantiated per client.

## Interface
- WIDTH, 8, dividend/divisor/quotient/remainder width in bits (≥2)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  2  per-requester request valid (bit i = requester i)
- req_ready  out  2  per-requester accept; one-hot or zero
- req0_dividend, req1_dividend  in  WIDTH  dividend per requester
- req0_divisor, req1_divisor  in  WIDTH  divisor per requester
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  1  requester that issued the result
- rsp_quotient  out  WIDTH  quotient
- rsp_remainder  out  WIDTH  remainder
- rsp_dbz  out  1  divide-by-zero flag (see Configuration)
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ITER, DONE.
- IDLE: grant = round-robin over req_valid. If both are valid, grant the requester that was not granted last. req_ready[g] = 1 only for the granted requester and only in IDLE; combinational from req_valid and the pointer.
- Accept (req_valid[g] & req_ready[g]):
  - q_reg ← dividend, d_reg ← divisor, rem ← 0 (WIDTH+1 bits), id ← g, pointer ← g, cnt ← WIDTH-1.
  - Next state ITER.
- ITER, one step per cycle:
  - {rem,q_reg} shifted left 1.
  - trial = rem − {0,d_reg}.
  - trial MSB = 1: rem unchanged (restore), q_reg[0] ← 0.
  - trial MSB = 0: rem ← trial, q_reg[0] ← 1.
  - cnt decrements. Leave for DONE after the step where cnt = 0.
- DONE: rsp_valid = 1. rsp_quotient = q_reg, rsp_remainder = rem[WIDTH-1:0], rsp_id = id. On rsp_valid & rsp_ready go to IDLE.
- Operands on req* ports are ignored outside the accept cycle.
- Reset values:
  - req_ready = 0 during reset.
  - rsp_valid = 0, rsp_id = 0, rsp_quotient = 0, rsp_remainder = 0, rsp_dbz = 0, busy = 0.
  - State = IDLE. Pointer = 1, so requester 0 wins the first tie.
- Reset mid-operation: the in-flight division is discarded and no response is issued. The requester re-requests.

## Timing
- Accept at cycle T. ITER runs T+1..T+WIDTH. rsp_valid first high at T+WIDTH+1.
- Latency is WIDTH+1 cycles to result; it is unaffected by operand values.
- rsp_* outputs are registered and held stable while rsp_valid & !rsp_ready.
- After a response handshake at cycle R, IDLE at R+1. The earliest next accept is R+1.
- Minimum issue interval is WIDTH+2 cycles.
- A requester dropping req_valid before ready is permitted. The grant re-evaluates each IDLE cycle.

## Configuration
- DIV_SCHED_DBZ_EN defined:
  - divisor = 0 is detected in the accept cycle.
  - ITER is skipped; state goes straight to DONE at T+1.
  - Result: rsp_quotient = all ones, rsp_remainder = dividend, rsp_dbz = 1.
- Undefined:
  - no detection; rsp_dbz tied 0.
  - A zero divisor runs the full WIDTH iterations and naturally yields quotient all ones, remainder = dividend, at T+WIDTH+1.

## Structure
- Package div_sched_pkg:
  - state enum (IDLE, ITER, DONE)
  - requester-id type
  - default WIDTH constant
- Sub-module div_rr_arb: 2-way round-robin arbiter.
  - Inputs: req[1:0], last-grant pointer, enable (state == IDLE).
  - Output: one-hot grant.
- Iteration datapath and FSM are inline in div_sched.

## Test plan
- WIDTH=8, req0 100/7 accepted at T -> rsp_valid at T+9, quotient 14, remainder 2, rsp_id 0, rsp_dbz 0.
- Both valid in the same cycle after reset:
  - req0 255/1 -> 255 r 0, id 0 first.
  - req1 5/9 -> 0 r 5, id 1 next.
  - Third tie -> requester 0 again.
- req1 13/0:
  - with DIV_SCHED_DBZ_EN -> rsp_valid at T+1, quotient 0xFF, remainder 13, rsp_dbz 1.
  - without -> same values at T+9 with rsp_dbz 0.
- Hold rsp_ready low 5 cycles after rsp_valid -> all rsp_* stable, req_ready stays 0, busy 1; release -> IDLE next cycle.
- Assert rst at ITER cycle 4 -> outputs return to reset values immediately, no response; a new 200/3 request after release -> 66 r 2.

Source files
------------

// File: rtl/div_sched_pkg.sv
// div_sched_pkg: shared types and defaults for the divider scheduler.
// Optional feature macro: DIV_SCHED_DBZ_EN (see div_sched.sv).
package div_sched_pkg;

    localparam int DIV_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        DONE
    } state_t;

    typedef logic rid_t;

endpackage

// File: rtl/div_rr_arb.sv
// div_rr_arb: 2-way round-robin arbiter; on a tie the requester
// that was not granted last wins.
module div_rr_arb
    import div_sched_pkg::*;
(
    input  logic [1:0] req,
    input  rid_t       last,
    input  logic       en,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/div_sched.sv
// div_sched: two-client scheduler around one restoring divider.
// Define DIV_SCHED_DBZ_EN to short-circuit divide-by-zero with rsp_dbz.
module div_sched
    import div_sched_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_dividend,
    input  logic [WIDTH-1:0] req1_dividend,
    input  logic [WIDTH-1:0] req0_divisor,
    input  logic [WIDTH-1:0] req1_divisor,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_quotient,
    output logic [WIDTH-1:0] rsp_remainder,
    output logic             rsp_dbz,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    state_t           state_n;
    rid_t             ptr;
    rid_t             id;
    rid_t             g;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] rem;
    logic [CW-1:0]    cnt;
    logic             dbz;
    logic [1:0]       gnt;
    logic             arb_en;
    logic             acc;
    logic             zdiv;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] q_sh;

    assign arb_en = (state == IDLE) && !rst;

    div_rr_arb u_arb (
        .req  (req_valid),
        .last (ptr),
        .en   (arb_en),
        .gnt  (gnt)
    );

    assign req_ready = gnt;
    assign acc       = |(req_valid & gnt);
    assign g         = gnt[1];
    assign a_sel     = g ? req1_dividend : req0_dividend;
    assign b_sel     = g ? req1_divisor  : req0_divisor;

    // Partial remainder stays below the divisor after every step, so only
    // the shifted value needs the extra bit.
    assign rem_sh = {rem, q[WIDTH-1]};
    assign q_sh   = {q[WIDTH-2:0], 1'b0};
    assign trial  = rem_sh - {1'b0, d};

`ifdef DIV_SCHED_DBZ_EN
    assign zdiv = (b_sel == '0);
`else
    assign zdiv = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (acc) state_n = zdiv ? DONE : ITER;
            ITER: if (cnt == '0) state_n = DONE;
            DONE: if (rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b1;
            id  <= 1'b0;
            q   <= '0;
            d   <= '0;
            rem <= '0;
            cnt <= '0;
            dbz <= 1'b0;
        end else if (acc) begin
            ptr <= g;
            id  <= g;
            d   <= b_sel;
            cnt <= CW'(WIDTH - 1);
            dbz <= zdiv;
            q   <= zdiv ? '1 : a_sel;
            rem <= zdiv ? a_sel : '0;
        end else if (state == ITER) begin
            cnt <= cnt - 1'b1;
            if (trial[WIDTH]) begin
                rem <= rem_sh[WIDTH-1:0];
                q   <= q_sh;
            end else begin
                rem <= trial[WIDTH-1:0];
                q   <= {q_sh[WIDTH-1:1], 1'b1};
            end
        end
    end

    assign rsp_valid     = (state == DONE);
    assign rsp_id        = id;
    assign rsp_quotient  = q;
    assign rsp_remainder = rem;
    assign rsp_dbz       = dbz;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_div_sched.sv
// tb_div_sched: randomized self-checking bench for div_sched
// against an arithmetic reference model.
module tb_div_sched;

    localparam int W = 8;
`ifdef DIV_SCHED_DBZ_EN
    localparam bit DBZ = 1'b1;
`else
    localparam bit DBZ = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [W-1:0] req0_dividend, req1_dividend;
    logic [W-1:0] req0_divisor, req1_divisor;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_dbz, busy;
    logic [W-1:0] rsp_quotient, rsp_remainder;

    div_sched #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req0_dividend (req0_dividend),
        .req1_dividend (req1_dividend),
        .req0_divisor  (req0_divisor),
        .req1_divisor  (req1_divisor),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_quotient  (rsp_quotient),
        .rsp_remainder (rsp_remainder),
        .rsp_dbz       (rsp_dbz),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int tests = 0;
    int fails = 0;
    int t0 = 0;

    // Reference: plain integer division, zero divisor gives all ones / dividend.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z, output int lat);
        if (b == 0) begin
            q = '1; r = a; z = DBZ; lat = DBZ ? 1 : W + 1;
        end else begin
            q = a / b; r = a % b; z = 1'b0; lat = W + 1;
        end
    endfunction

    task automatic drive(input bit rid, input logic [W-1:0] a, input logic [W-1:0] b);
        if (rid) begin
            req1_dividend = a; req1_divisor = b;
        end else begin
            req0_dividend = a; req0_divisor = b;
        end
        req_valid[rid] = 1'b1;
    endtask

    task automatic scramble();
        req0_dividend = W'($urandom); req0_divisor = W'($urandom);
        req1_dividend = W'($urandom); req1_divisor = W'($urandom);
    endtask

    // Called at a negedge; returns with t0 set to the accept cycle.
    task automatic wait_grant(input logic [1:0] want, output bit ok);
        int n = 0;
        #1;
        while (req_ready !== want && n < 40) begin
            @(negedge clk); #1; n++;
        end
        ok = (req_ready === want);
        t0 = cyc;
    endtask

    task automatic collect(output logic [W-1:0] q, output logic [W-1:0] r,
                           output logic id, output logic z, output int lat,
                           output bit ok);
        int n = 0;
        while (rsp_valid !== 1'b1 && n < 40) begin
            @(negedge clk); n++;
        end
        ok  = (rsp_valid === 1'b1);
        lat = cyc - t0;
        q   = rsp_quotient;
        r   = rsp_remainder;
        id  = rsp_id;
        z   = rsp_dbz;
        rsp_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_one(input bit rid, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] q, output logic [W-1:0] r,
                           output logic id, output logic z, output int lat,
                           output bit ok);
        bit okg, okc;
        drive(rid, a, b);
        wait_grant(rid ? 2'b10 : 2'b01, okg);
        @(negedge clk);
        req_valid = 2'b00;
        scramble();
        collect(q, r, id, z, lat, okc);
        ok = okg && okc;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        scramble();
        repeat (2) @(negedge clk);
        tests++;
        if (req_ready !== 2'b00 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl: ready=%b valid=%b busy=%b, want 00 0 0",
                     req_ready, rsp_valid, busy);
        end
        tests++;
        if (rsp_quotient !== '0 || rsp_remainder !== '0 || rsp_id !== 1'b0 || rsp_dbz !== 1'b0) begin
            fails++;
            $display("FAIL reset_data: q=%0d r=%0d id=%0d dbz=%0d, want all 0",
                     rsp_quotient, rsp_remainder, rsp_id, rsp_dbz);
        end
        req_valid = 2'b00;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [W-1:0] q, r; logic id, z; int lat; bit ok;
        run_one(1'b0, 8'd100, 8'd7, q, r, id, z, lat, ok);
        tests++;
        if (!ok || q !== 8'd14 || r !== 8'd2 || id !== 1'b0 || z !== 1'b0 || lat != W + 1) begin
            fails++;
            $display("FAIL basic_100_7: got ok=%0d q=%0d r=%0d id=%0d dbz=%0d lat=%0d, want 1 14 2 0 0 %0d",
                     ok, q, r, id, z, lat, W + 1);
        end
    endtask

    task automatic test_tie();
        logic [W-1:0] q, r; logic id, z; int lat; bit ok, okc;
        do_reset();
        drive(1'b0, 8'd255, 8'd1);
        drive(1'b1, 8'd5, 8'd9);
        wait_grant(2'b01, ok);
        tests++;
        if (!ok || t0 != cyc) begin
            fails++;
            $display("FAIL tie1_grant: ready=%b, want 01", req_ready);
        end
        @(negedge clk);
        req_valid[0] = 1'b0;
        collect(q, r, id, z, lat, okc);
        tests++;
        if (!okc || q !== 8'd255 || r !== 8'd0 || id !== 1'b0 || lat != W + 1) begin
            fails++;
            $display("FAIL tie1_rsp: got q=%0d r=%0d id=%0d lat=%0d, want 255 0 0 %0d",
                     q, r, id, lat, W + 1);
        end
        wait_grant(2'b10, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL tie2_grant: ready=%b, want 10", req_ready);
        end
        @(negedge clk);
        req_valid = 2'b00;
        collect(q, r, id, z, lat, okc);
        tests++;
        if (!okc || q !== 8'd0 || r !== 8'd5 || id !== 1'b1 || lat != W + 1) begin
            fails++;
            $display("FAIL tie2_rsp: got q=%0d r=%0d id=%0d lat=%0d, want 0 5 1 %0d",
                     q, r, id, lat, W + 1);
        end
        drive(1'b0, 8'd50, 8'd6);
        drive(1'b1, 8'd60, 8'd7);
        wait_grant(2'b01, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL tie3_grant: ready=%b, want 01", req_ready);
        end
        @(negedge clk);
        req_valid = 2'b00;
        collect(q, r, id, z, lat, okc);
        tests++;
        if (!okc || q !== 8'd8 || r !== 8'd2 || id !== 1'b0) begin
            fails++;
            $display("FAIL tie3_rsp: got q=%0d r=%0d id=%0d, want 8 2 0", q, r, id);
        end
    endtask

    task automatic test_dbz();
        logic [W-1:0] q, r; logic id, z; int lat; bit ok;
        run_one(1'b1, 8'd13, 8'd0, q, r, id, z, lat, ok);
        tests++;
        if (!ok || q !== 8'hFF || r !== 8'd13 || id !== 1'b1 || z !== DBZ
            || lat != (DBZ ? 1 : W + 1)) begin
            fails++;
            $display("FAIL dbz_13_0: got q=%0d r=%0d id=%0d dbz=%0d lat=%0d, want 255 13 1 %0d %0d",
                     q, r, id, z, lat, DBZ, DBZ ? 1 : W + 1);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] sq, sr; logic sid, sz; bit ok; int n;
        drive(1'b0, 8'd100, 8'd7);
        wait_grant(2'b01, ok);
        @(negedge clk);
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        drive(1'b1, 8'd9, 8'd2);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 40) begin
            @(negedge clk); n++;
        end
        tests++;
        if (!ok || rsp_valid !== 1'b1 || cyc - t0 != W + 1 || rsp_quotient !== 8'd14
            || rsp_remainder !== 8'd2) begin
            fails++;
            $display("FAIL bp_first: valid=%b lat=%0d q=%0d r=%0d, want 1 %0d 14 2",
                     rsp_valid, cyc - t0, rsp_quotient, rsp_remainder, W + 1);
        end
        sq = rsp_quotient; sr = rsp_remainder; sid = rsp_id; sz = rsp_dbz;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            scramble();
            tests++;
            if (rsp_valid !== 1'b1 || rsp_quotient !== sq || rsp_remainder !== sr
                || rsp_id !== sid || rsp_dbz !== sz || req_ready !== 2'b00 || busy !== 1'b1) begin
                fails++;
                $display("FAIL bp_hold%0d: valid=%b q=%0d r=%0d id=%0d ready=%b busy=%b, want 1 %0d %0d %0d 00 1",
                         i, rsp_valid, rsp_quotient, rsp_remainder, rsp_id, req_ready, busy, sq, sr, sid);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 2'b10) begin
            fails++;
            $display("FAIL bp_release: valid=%b busy=%b ready=%b, want 0 0 10",
                     rsp_valid, busy, req_ready);
        end
        req_valid = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        logic [W-1:0] q, r; logic id, z; int lat; bit ok; int seen;
        drive(1'b0, 8'd100, 8'd7);
        wait_grant(2'b01, ok);
        @(negedge clk);
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        req_valid = 2'b11;
        #1;
        tests++;
        if (!ok || rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 2'b00
            || rsp_quotient !== '0 || rsp_remainder !== '0 || rsp_id !== 1'b0 || rsp_dbz !== 1'b0) begin
            fails++;
            $display("FAIL midrst_outputs: valid=%b busy=%b ready=%b q=%0d r=%0d id=%0d dbz=%0d, want all 0",
                     rsp_valid, busy, req_ready, rsp_quotient, rsp_remainder, rsp_id, rsp_dbz);
        end
        @(negedge clk);
        rst = 1'b0;
        req_valid = 2'b00;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL midrst_norsp: rsp_valid cycles=%0d, want 0", seen);
        end
        run_one(1'b0, 8'd200, 8'd3, q, r, id, z, lat, ok);
        tests++;
        if (!ok || q !== 8'd66 || r !== 8'd2 || id !== 1'b0 || lat != W + 1) begin
            fails++;
            $display("FAIL midrst_200_3: got q=%0d r=%0d id=%0d lat=%0d, want 66 2 0 %0d",
                     q, r, id, lat, W + 1);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a0, b0, a1, b1, ea, eb, eq, er, q, r;
        logic ez, id, z; int el, lat; bit ok, okc;
        logic [1:0] pat; bit g, last;
        do_reset();
        last = 1'b1;
        for (int i = 0; i < 40; i++) begin
            pat = 2'($urandom_range(1, 3));
            a0 = W'($urandom); a1 = W'($urandom);
            b0 = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            b1 = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            g = (pat == 2'b11) ? !last : pat[1];
            ea = g ? a1 : a0;
            eb = g ? b1 : b0;
            model(ea, eb, eq, er, ez, el);
            if (pat[0]) drive(1'b0, a0, b0);
            if (pat[1]) drive(1'b1, a1, b1);
            wait_grant(g ? 2'b10 : 2'b01, ok);
            @(negedge clk);
            req_valid = 2'b00;
            scramble();
            collect(q, r, id, z, lat, okc);
            tests++;
            if (!ok || !okc || q !== eq || r !== er || id !== g || z !== ez || lat != el) begin
                fails++;
                $display("FAIL rand%0d %0d/%0d pat=%b: got q=%0d r=%0d id=%0d dbz=%0d lat=%0d, want %0d %0d %0d %0d %0d",
                         i, ea, eb, pat, q, r, id, z, lat, eq, er, g, ez, el);
            end
            last = g;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        rst = 1'b1;
        scramble();
        test_reset();
        test_basic();
        test_tie();
        test_dbz();
        test_backpressure();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
